// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, data-memory req/ready port,
// load alignment/extension, write-back select and MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  NextDInSrc,
  input  logic        NextRegWE,
  input  logic [5:0]  NextRegWAddr,
  input  logic [1:0]  NextMEMSize,
  input  logic        NextMEMWE,
  input  logic        NextExtMEM,
  input  logic [31:0] NextALUOut,
  input  logic [31:0] NextFPUOut,
  input  logic [31:0] NextRegB,
  input  logic [31:0] NextPCPlusFour,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        MemStall,
  output logic [31:0] MemData,
  output logic        WBRegWE,
  output logic [5:0]  WBRegWAddr,
  output logic [31:0] WBData,
  output logic [15:0] MemWaitCount
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic [1:0]  src_q;
  logic        reg_we_q;
  logic [5:0]  waddr_q;
  logic [1:0]  size_q;
  logic        mem_we_q;
  logic        ext_q;
  logic [31:0] alu_q, fpu_q, reg_b_q, pc4_q;

  logic        wb_we_q;
  logic [5:0]  wb_waddr_q;
  logic [31:0] wb_data_q, wb_data_d;
  logic [15:0] wait_cnt_q;

  logic        mem_op;
  logic [1:0]  off;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign mem_op   = mem_we_q | (src_q == 2'b01);
  assign off      = alu_q[1:0];
  assign MemStall = mem_op & ~dmem_ready;

  // EX/MEM register: frozen while an access waits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q    <= 2'b00;
      reg_we_q <= 1'b0;
      waddr_q  <= 6'd0;
      size_q   <= 2'b00;
      mem_we_q <= 1'b0;
      ext_q    <= 1'b0;
      alu_q    <= 32'd0;
      fpu_q    <= 32'd0;
      reg_b_q  <= 32'd0;
      pc4_q    <= 32'd0;
    end else if (!MemStall) begin
      src_q    <= NextDInSrc;
      reg_we_q <= NextRegWE;
      waddr_q  <= NextRegWAddr;
      size_q   <= NextMEMSize;
      mem_we_q <= NextMEMWE;
      ext_q    <= NextExtMEM;
      alu_q    <= NextALUOut;
      fpu_q    <= NextFPUOut;
      reg_b_q  <= NextRegB;
      pc4_q    <= NextPCPlusFour;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_op && !dmem_ready) state_d = StWait;
      StWait: if (dmem_ready || !mem_op) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane 0 is the most significant byte; be[3] enables lane 0.
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = reg_b_q;
    unique case (size_q)
      2'b00: begin
        be_raw    = 4'b1000 >> off;
        wdata_raw = {4{reg_b_q[7:0]}};
      end
      2'b01: begin
        be_raw    = off[1] ? 4'b0011 : 4'b1100;
        wdata_raw = {2{reg_b_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = reg_b_q;
      end
    endcase
  end

  assign dmem_req   = mem_op;
  assign dmem_we    = mem_we_q;
  assign dmem_addr  = {alu_q[31:2], 2'b00};
  assign dmem_be    = mem_op ? be_raw : 4'b0000;
  assign dmem_wdata = mem_we_q ? wdata_raw : 32'd0;

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off)
      2'd0:    ld_byte = dmem_rdata[31:24];
      2'd1:    ld_byte = dmem_rdata[23:16];
      2'd2:    ld_byte = dmem_rdata[15:8];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = off[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    case (size_q)
      2'b00:   ld_data = {{24{ext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ext_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    wb_data_d = alu_q;
    unique case (src_q)
      2'b00: wb_data_d = alu_q;
      2'b01: wb_data_d = ld_data;
      2'b10: wb_data_d = pc4_q;
      2'b11: wb_data_d = fpu_q;
      default: wb_data_d = alu_q;
    endcase
  end

  // MEM/WB register: a stall inserts a bubble but keeps address/data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_we_q    <= 1'b0;
      wb_waddr_q <= 6'd0;
      wb_data_q  <= 32'd0;
    end else if (MemStall) begin
      wb_we_q    <= 1'b0;
    end else begin
      wb_we_q    <= reg_we_q;
      wb_waddr_q <= waddr_q;
      wb_data_q  <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= 16'd0;
    end else if (MemStall && (wait_cnt_q != 16'hFFFF)) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign MemData      = alu_q;
  assign WBRegWE      = wb_we_q;
  assign WBRegWAddr   = wb_waddr_q;
  assign WBData       = wb_data_q;
  assign MemWaitCount = wait_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a driver issues instructions and
// plays the memory, a monitor pops expected requests/write-backs and compares.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  NextDInSrc;
  logic        NextRegWE;
  logic [5:0]  NextRegWAddr;
  logic [1:0]  NextMEMSize;
  logic        NextMEMWE;
  logic        NextExtMEM;
  logic [31:0] NextALUOut, NextFPUOut, NextRegB, NextPCPlusFour;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        MemStall;
  logic [31:0] MemData;
  logic        WBRegWE;
  logic [5:0]  WBRegWAddr;
  logic [31:0] WBData;
  logic [15:0] MemWaitCount;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE), .NextRegWAddr(NextRegWAddr),
    .NextMEMSize(NextMEMSize), .NextMEMWE(NextMEMWE), .NextExtMEM(NextExtMEM),
    .NextALUOut(NextALUOut), .NextFPUOut(NextFPUOut), .NextRegB(NextRegB),
    .NextPCPlusFour(NextPCPlusFour), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .MemStall(MemStall), .MemData(MemData),
    .WBRegWE(WBRegWE), .WBRegWAddr(WBRegWAddr), .WBData(WBData),
    .MemWaitCount(MemWaitCount)
  );

  typedef struct {
    logic [1:0]  src;
    logic        reg_we;
    logic [5:0]  waddr;
    logic [1:0]  size;
    logic        mwe;
    logic        ext;
    logic [31:0] alu, fpu, rb, pc4, rdata;
    int          k;
  } instr_t;
  typedef struct { logic [5:0] waddr; logic [31:0] data; } wb_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  wb_t    wbq[$];
  req_t   reqq[$];
  instr_t dirq[$];

  instr_t cur, in_r;
  bit     acc, draining;
  int     waited, issued, cycles, total_stall;
  localparam int NumInstr = 300;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: big-endian byte numbering, byte offset = address mod 4.
  function automatic bit is_mem(instr_t i);
    return i.mwe || (i.src == 2'd1);
  endfunction

  function automatic logic [31:0] load_value(instr_t i);
    int unsigned o = i.alu % 4;
    int unsigned v;
    if (i.size == 2'd0) begin
      v = (i.rdata >> (8 * (3 - o))) & 32'hFF;
      if (i.ext && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (i.size == 2'd1) begin
      v = (i.rdata >> (16 * (1 - o / 2))) & 32'hFFFF;
      if (i.ext && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = i.rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] wb_value(instr_t i);
    case (i.src)
      2'd0:    return i.alu;
      2'd1:    return load_value(i);
      2'd2:    return i.pc4;
      default: return i.fpu;
    endcase
  endfunction

  function automatic req_t req_of(instr_t i);
    req_t r;
    int unsigned o = i.alu % 4;
    r.addr = i.alu - o;
    r.we   = i.mwe;
    if (i.size == 2'd0) begin
      r.be    = 4'(8 >> o);
      r.wdata = (i.rb & 32'hFF) * 32'h0101_0101;
    end else if (i.size == 2'd1) begin
      r.be    = (o < 2) ? 4'hC : 4'h3;
      r.wdata = (i.rb & 32'hFFFF) * 32'h0001_0001;
    end else begin
      r.be    = 4'hF;
      r.wdata = i.rb;
    end
    return r;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i = '{src: 2'd0, reg_we: 1'b0, waddr: 6'd0, size: 2'd0, mwe: 1'b0, ext: 1'b0,
          alu: 32'd0, fpu: 32'd0, rb: 32'd0, pc4: 32'd0, rdata: 32'd0, k: 0};
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.src    = 2'($urandom_range(0, 3));
    i.reg_we = 1'($urandom_range(0, 1));
    i.waddr  = 6'($urandom_range(0, 63));
    i.size   = 2'($urandom_range(0, 3));
    i.mwe    = ($urandom_range(0, 2) == 0);
    i.ext    = 1'($urandom_range(0, 1));
    i.alu    = $urandom;
    i.fpu    = $urandom;
    i.rb     = $urandom;
    i.pc4    = $urandom;
    i.rdata  = $urandom;
    i.k      = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
    return i;
  endfunction

  task automatic drive(input instr_t i);
    NextDInSrc     = i.src;
    NextRegWE      = i.reg_we;
    NextRegWAddr   = i.waddr;
    NextMEMSize    = i.size;
    NextMEMWE      = i.mwe;
    NextExtMEM     = i.ext;
    NextALUOut     = i.alu;
    NextFPUOut     = i.fpu;
    NextRegB       = i.rb;
    NextPCPlusFour = i.pc4;
  endtask

  // One cycle of driver + memory responder; expectations pushed on acceptance.
  task automatic step();
    bit exp_stall;
    @(negedge clk);
    cycles++;
    if (acc) begin
      if (draining)               cur = nop();
      else if (dirq.size() != 0)  cur = dirq.pop_front();
      else                        cur = rand_instr();
      drive(cur);
    end
    if (is_mem(in_r)) begin
      dmem_ready = (waited >= in_r.k);
      dmem_rdata = dmem_ready ? in_r.rdata : $urandom;
    end else begin
      dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
    end
    #1;
    exp_stall = is_mem(in_r) && (waited < in_r.k);
    chk("mem_stall", 32'(MemStall), 32'(exp_stall));
    chk("mem_data", MemData, in_r.alu);
    if (exp_stall) begin
      waited++;
      total_stall++;
      acc = 1'b0;
    end else begin
      if (cur.reg_we) wbq.push_back('{waddr: cur.waddr, data: wb_value(cur)});
      if (is_mem(cur)) reqq.push_back(req_of(cur));
      in_r   = cur;
      waited = 0;
      acc    = 1'b1;
      if (!draining) issued++;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue heads.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (dmem_req) begin
        if (reqq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got req addr %h expected no request", dmem_addr);
        end else begin
          chk("req_addr", dmem_addr, reqq[0].addr);
          chk("req_we", 32'(dmem_we), 32'(reqq[0].we));
          chk("req_be", 32'(dmem_be), 32'(reqq[0].be));
          if (reqq[0].we) chk("req_wdata", dmem_wdata, reqq[0].wdata);
          if (dmem_ready) void'(reqq.pop_front());
        end
      end else begin
        chk("idle_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
        chk("idle_wdata", dmem_wdata, 32'd0);
      end
      if (WBRegWE) begin
        if (wbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got write to r%0d expected none", WBRegWAddr);
        end else begin
          chk("wb_waddr", 32'(WBRegWAddr), 32'(wbq[0].waddr));
          chk("wb_data", WBData, wbq[0].data);
          void'(wbq.pop_front());
        end
      end
    end
  end

  initial begin
    instr_t d;
    // Reset with random inputs present.
    reset = 1'b0;
    drive(rand_instr());
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
    chk("rst_stall", 32'(MemStall), 32'd0);
    chk("rst_wbwe", 32'(WBRegWE), 32'd0);
    chk("rst_wbaddr", 32'(WBRegWAddr), 32'd0);
    chk("rst_wbdata", WBData, 32'd0);
    chk("rst_memdata", MemData, 32'd0);
    chk("rst_waitcnt", 32'(MemWaitCount), 32'd0);
    drive(nop());
    reset = 1'b1;

    // Directed cases first, then random traffic.
    d = nop(); d.reg_we = 1'b1; d.waddr = 6'd5; d.alu = 32'h1234_5678; d.pc4 = 32'h44;
    dirq.push_back(d);
    d = nop(); d.src = 2'd1; d.reg_we = 1'b1; d.waddr = 6'd7; d.ext = 1'b1;
    d.alu = 32'h103; d.rdata = 32'hAABB_CC80;
    dirq.push_back(d);
    d.ext = 1'b0; d.waddr = 6'd8;
    dirq.push_back(d);
    d = nop(); d.mwe = 1'b1; d.size = 2'd1; d.alu = 32'h202; d.rb = 32'hDEAD_BEEF;
    dirq.push_back(d);
    d = nop(); d.src = 2'd1; d.reg_we = 1'b1; d.waddr = 6'd9; d.size = 2'd2;
    d.alu = 32'h400; d.rdata = 32'hCAFE_F00D; d.k = 3;
    dirq.push_back(d);

    in_r = nop();
    cur = nop();
    acc = 1'b1;
    draining = 1'b0;
    waited = 0;
    issued = 0;
    cycles = 0;
    total_stall = 0;
    mon_en = 1'b1;
    while (issued < NumInstr && cycles < 5000) step();
    if (issued < NumInstr) begin
      checks++;
      errors++;
      $display("FAIL cycle_budget: got %0d issued expected %0d", issued, NumInstr);
    end
    draining = 1'b1;
    repeat (8) step();
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
    chk("req_queue_drained", 32'(reqq.size()), 32'd0);
    chk("wait_count", 32'(MemWaitCount), 32'(total_stall));

    // Reset while an access is waiting; a late ready must not write back.
    d = nop(); d.src = 2'd1; d.reg_we = 1'b1; d.waddr = 6'd3; d.size = 2'd2; d.alu = 32'h800;
    drive(d);
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("wait_req", 32'(dmem_req), 32'd1);
    chk("wait_stall", 32'(MemStall), 32'd1);
    drive(nop());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rstwait_req", 32'(dmem_req), 32'd0);
    chk("rstwait_waitcnt", 32'(MemWaitCount), 32'd0);
    reset = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = $urandom;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rstwait_no_wb", 32'(WBRegWE), 32'd0);
      chk("rstwait_req_low", 32'(dmem_req), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
